// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: 16-bit big-endian word count, then N big-endian 32-bit words.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int AW = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_resetn,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int DEPTH = 1 << AW;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;
`endif

  state_t        state_r;
  logic [7:0]    len_hi_r;
  logic [AW:0]   num_words_r;
  logic [AW:0]   word_idx_r;
  logic [1:0]    byte_cnt_r;
  logic [23:0]   shift_r;
  logic          rx_ready_r;
  logic          wr_en_r;
  logic [AW-1:0] wr_addr_r;
  logic [31:0]   wr_data_r;
  logic          cpu_resetn_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_r;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  logic          accept_s;
  logic [15:0]   len_s;
  logic          len_too_big_s;
  logic          last_word_s;
  logic [31:0]   word_s;

  // Per-byte decode of the incoming stream against the current state.
  always_comb begin
    accept_s      = rx_valid & rx_ready_r;
    len_s         = {len_hi_r, rx_data};
    len_too_big_s = ({16'd0, len_s} > 32'(DEPTH));
    last_word_s   = ((word_idx_r + {{AW{1'b0}}, 1'b1}) == num_words_r);
    word_s        = {shift_r, rx_data};
  end

  // Loader FSM; every output is registered and updated on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= LEN_HI;
      len_hi_r     <= 8'd0;
      num_words_r  <= '0;
      word_idx_r   <= '0;
      byte_cnt_r   <= 2'd0;
      shift_r      <= 24'd0;
      rx_ready_r   <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= 32'd0;
      cpu_resetn_r <= 1'b0;
      busy_r       <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r       <= 8'd0;
`endif
    end else begin
      wr_en_r      <= 1'b0;
      cpu_resetn_r <= (state_r == DONE);
      rx_ready_r   <= (state_r != DONE) && (state_r != ERR);
      case (state_r)
        LEN_HI: begin
          if (accept_s) begin
            len_hi_r <= rx_data;
            state_r  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept_s) begin
            num_words_r <= len_s[AW:0];
            if (len_too_big_s) begin
              state_r    <= ERR;
              rx_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              err_r      <= 1'b1;
            end else if (len_s == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_r    <= CHK;
`else
              state_r    <= DONE;
              rx_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
`endif
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r <= csum_next(csum_r, rx_data);
`endif
            if (byte_cnt_r == 2'd3) begin
              wr_en_r    <= 1'b1;
              wr_data_r  <= word_s;
              wr_addr_r  <= word_idx_r[AW-1:0];
              word_idx_r <= word_idx_r + {{AW{1'b0}}, 1'b1};
              byte_cnt_r <= 2'd0;
              shift_r    <= 24'd0;
              if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_r    <= CHK;
`else
                state_r    <= DONE;
                rx_ready_r <= 1'b0;
                busy_r     <= 1'b0;
                done_r     <= 1'b1;
`endif
              end
            end else begin
              shift_r    <= {shift_r[15:0], rx_data};
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept_s) begin
            rx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            if (rx_data == csum_r) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ERR;
              err_r   <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          state_r <= DONE;
        end
        ERR: begin
          state_r <= ERR;
        end
        default: begin
          state_r    <= ERR;
          rx_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          err_r      <= 1'b1;
        end
      endcase
    end
  end

  assign rx_ready   = rx_ready_r;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign cpu_resetn = cpu_resetn_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are driven, popped on wr_en.
module tb_imem_loader;

  localparam int AW = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_resetn;
  logic          busy;
  logic          done;
  logic          err;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    img_q[$];
  longint         wr_times[$];

  imem_loader #(.AW(AW)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_resetn(cpu_resetn), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      logic [AW+31:0] e;
      wr_count++;
      wr_times.push_back($time);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          miscompares++;
          $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr, wr_data, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: rx_ready=%b, required 1", rx_ready);
    end
    rx_valid = 1'b1; rx_data = b;
    @(posedge clock); #1;
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    rx_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic load_image(input logic [15:0] n, input bit gap, input bit bad_chk);
    logic [7:0]    x;
    logic [7:0]    b;
    logic [AW-1:0] a;
    x = 8'd0;
    send_byte(n[15:8]);
    if (gap) idle_cycle();
    send_byte(n[7:0]);
    for (int i = 0; i < img_q.size(); i++) begin
      a = i[AW-1:0];
      exp_q.push_back({a, img_q[i]});
      for (int k = 0; k < 4; k++) begin
        b = img_q[i][31-8*k -: 8];
        x = x ^ b;
        if (gap) idle_cycle();
        send_byte(b);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (gap) idle_cycle();
    send_byte(x ^ {7'd0, bad_chk});
`endif
  endtask

  task automatic check_done_tail(input string nm);
    @(negedge clock);
    vectors++;
    if ({done, err, busy, rx_ready, cpu_resetn} !== 5'b10000) begin
      miscompares++;
      $display("FAIL %s_done_entry: done/err/busy/ready/cpu_resetn=%b, required 10000", nm,
               {done, err, busy, rx_ready, cpu_resetn});
    end
    @(negedge clock);
    vectors++;
    if (cpu_resetn !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_cpu_resetn: got %b, required 1", nm, cpu_resetn);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    vectors++;
    if ({rx_ready, wr_en, wr_addr, wr_data, cpu_resetn, busy, done, err} !== {3'b000, 32'd0, 4'b0100} ||
        wr_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b wr_en=%b addr=%0d data=%h cpu_resetn=%b busy=%b done=%b err=%b",
               rx_ready, wr_en, wr_addr, wr_data, cpu_resetn, busy, done, err);
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (rx_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b busy=%b, required 1 1", rx_ready, busy);
    end
  endtask

  task automatic test_stream(input bit gap);
    int base;
    apply_reset();
    base = wr_count;
    wr_times.delete();
    img_q = '{32'h12345678, 32'h9ABCDEF0};
    load_image(16'd2, gap, 1'b0);
    check_done_tail(gap ? "gapped" : "back_to_back");
    repeat (8) @(negedge clock);
    vectors++;
    if (wr_count - base != 2 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_writes: got %0d writes, %0d pending, required 2 and 0", wr_count - base, exp_q.size());
    end
    vectors++;
    if (wr_times.size() != 2 || (wr_times[1] - wr_times[0]) != (gap ? 80 : 40)) begin
      miscompares++;
      $display("FAIL stream_spacing: got %0d ns, required %0d ns",
               (wr_times.size() == 2) ? (wr_times[1] - wr_times[0]) : -1, gap ? 80 : 40);
    end
    vectors++;
    if (wr_addr !== 6'd1 || wr_data !== 32'h9ABCDEF0 || rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_hold: addr=%0d data=%h ready=%b, required 1 9abcdef0 0", wr_addr, wr_data, rx_ready);
    end
  endtask

  task automatic test_len_err();
    int base;
    apply_reset();
    base = wr_count;
    send_byte(8'h00);
    send_byte(8'h41);
    @(negedge clock);
    vectors++;
    if ({err, done, busy, rx_ready, cpu_resetn} !== 5'b10000) begin
      miscompares++;
      $display("FAIL len_err_state: err/done/busy/ready/cpu_resetn=%b, required 10000",
               {err, done, busy, rx_ready, cpu_resetn});
    end
    rx_data = 8'h55;
    repeat (10) @(negedge clock);
    vectors++;
    if (wr_count != base || cpu_resetn !== 1'b0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL len_err_hold: writes=%0d cpu_resetn=%b err=%b, required 0 0 1", wr_count - base, cpu_resetn, err);
    end
  endtask

  task automatic test_full_depth();
    int base;
    apply_reset();
    base = wr_count;
    img_q.delete();
    for (int i = 0; i < 64; i++) img_q.push_back($urandom);
    load_image(16'd64, 1'b0, 1'b0);
    check_done_tail("full_depth");
    repeat (3) @(negedge clock);
    vectors++;
    if (wr_count - base != 64 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL full_depth_writes: got %0d, required 64", wr_count - base);
    end
  endtask

  task automatic test_reset_mid_word();
    int base;
    apply_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clock);
    reset = 1'b1; rx_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if ({rx_ready, wr_en, busy, done, err} !== 5'b00100 || wr_data !== 32'd0 || wr_addr !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_state: ready/wr_en/busy/done/err=%b addr=%0d data=%h, required 00100 0 0",
               {rx_ready, wr_en, busy, done, err}, wr_addr, wr_data);
    end
    reset = 1'b0;
    base = wr_count;
    img_q = '{32'hDEADBEEF};
    load_image(16'd1, 1'b0, 1'b0);
    check_done_tail("mid_reset");
    repeat (3) @(negedge clock);
    vectors++;
    if (wr_count - base != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset_writes: got %0d, required 1", wr_count - base);
    end
  endtask

  task automatic test_zero_len();
    int base;
    apply_reset();
    base = wr_count;
    img_q.delete();
    load_image(16'd0, 1'b0, 1'b0);
    check_done_tail("zero_len");
    repeat (4) @(negedge clock);
    vectors++;
    if (wr_count != base) begin
      miscompares++;
      $display("FAIL zero_len_writes: got %0d, required 0", wr_count - base);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int base;
    apply_reset();
    img_q = '{32'h01020304};
    load_image(16'd1, 1'b0, 1'b0);
    check_done_tail("chk_good");
    apply_reset();
    base = wr_count;
    load_image(16'd1, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    vectors++;
    if ({err, done, cpu_resetn} !== 3'b100 || wr_count - base != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL chk_bad: err/done/cpu_resetn=%b writes=%0d, required 100 and 1",
               {err, done, cpu_resetn}, wr_count - base);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream(1'b0);
    test_stream(1'b1);
    test_len_err();
    test_full_depth();
    test_reset_mid_word();
    test_zero_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
